// File: rtl/i2c_master.sv
// i2c_master: single-master I2C write/read engine.
//
// Each I2C bit takes four clk cycles (phases P0..P3). scl is low in P0/P1
// and high in P2/P3. sda_out only moves at the start of P0 (except inside
// the START/STOP conditions), and the line is sampled at the end of P3.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      transaction request, accepted only while ready=1
//   addr       7-bit target address
//   rw         0 = write, 1 = read
//   packets    number of data bytes (values above 16 are treated as 16)
//   data       write payload, byte i at data[i*8 +: 8], byte 0 sent first
//   ready      1 = idle and able to accept start
//   rdata      read payload, byte i at rdata[i*8 +: 8]
//   ack_error  set when a slave NACK aborts the transaction
//   scl        I2C clock (push-pull)
//   sda_out    open-drain control, 0 = pull low, 1 = release
//   sda_in     sampled SDA line level
module i2c_master (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [6:0]   addr,
  input  logic         rw,
  input  logic [4:0]   packets,
  input  logic [127:0] data,
  output logic         ready,
  output logic [127:0] rdata,
  output logic         ack_error,
  output logic         scl,
  output logic         sda_out,
  input  logic         sda_in
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  state_t         state_reg;
  logic [1:0]     phase_reg;
  logic [2:0]     bit_reg;
  logic [3:0]     byte_reg;
  logic [4:0]     count_reg;
  logic           rw_reg;
  logic [6:0]     addr_reg;
  logic [127:0]   data_reg;
  logic [6:0]     shift_reg;

  logic [7:0]     addr_byte;
  logic [7:0]     tx_byte;
  logic [7:0]     tx_next_byte;
  logic [3:0]     byte_inc;
  logic [2:0]     bit_dec;
  logic [7:0]     rx_byte;
  logic           last_byte;

  always_comb begin
    addr_byte    = {addr_reg, rw_reg};
    byte_inc     = byte_reg + 4'd1;
    bit_dec      = bit_reg - 3'd1;
    tx_byte      = data_reg[{byte_reg, 3'b000} +: 8];
    // Only consulted when another byte follows, so the wrap at 15 is harmless.
    tx_next_byte = data_reg[{byte_inc, 3'b000} +: 8];
    rx_byte      = {shift_reg, sda_in};
    last_byte    = ({1'b0, byte_reg} == (count_reg - 5'd1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      phase_reg <= 2'd0;
      bit_reg   <= 3'd0;
      byte_reg  <= 4'd0;
      count_reg <= 5'd0;
      rw_reg    <= 1'b0;
      addr_reg  <= 7'd0;
      data_reg  <= '0;
      shift_reg <= 7'd0;
      ready     <= 1'b1;
      rdata     <= '0;
      ack_error <= 1'b0;
      scl       <= 1'b1;
      sda_out   <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg  <= addr;
            rw_reg    <= rw;
            data_reg  <= data;
            count_reg <= (packets > 5'd16) ? 5'd16 : packets;
            ack_error <= 1'b0;
            ready     <= 1'b0;
            phase_reg <= 2'd0;
            scl       <= 1'b1;
            sda_out   <= 1'b1;
            state_reg <= START;
          end
        end

        // scl stays high; sda falls halfway through.
        START: begin
          phase_reg <= phase_reg + 2'd1;
          if (phase_reg == 2'd1) begin
            sda_out <= 1'b0;
          end
          if (phase_reg == 2'd3) begin
            scl       <= 1'b0;
            sda_out   <= addr_byte[7];
            bit_reg   <= 3'd7;
            state_reg <= ADDR;
          end
        end

        // Low for two phases, scl rises, then sda rises while scl is high.
        STOP: begin
          phase_reg <= phase_reg + 2'd1;
          case (phase_reg)
            2'd1:    scl <= 1'b1;
            2'd2:    sda_out <= 1'b1;
            2'd3: begin
              ready     <= 1'b1;
              state_reg <= IDLE;
            end
            default: ;
          endcase
        end

        // All bit-carrying states share the same 4-phase scl pattern; the
        // decision for the next bit is taken at the end of P3, which is
        // also where sda_in is sampled.
        default: begin
          phase_reg <= phase_reg + 2'd1;
          if (phase_reg == 2'd1) begin
            scl <= 1'b1;
          end
          if (phase_reg == 2'd3) begin
            scl <= 1'b0;
            case (state_reg)
              ADDR: begin
                if (bit_reg == 3'd0) begin
                  sda_out   <= 1'b1;
                  state_reg <= ADDR_ACK;
                end else begin
                  bit_reg <= bit_dec;
                  sda_out <= addr_byte[bit_dec];
                end
              end

              ADDR_ACK: begin
                if (sda_in) begin
                  ack_error <= 1'b1;
                  sda_out   <= 1'b0;
                  state_reg <= STOP;
                end else if (count_reg == 5'd0) begin
                  sda_out   <= 1'b0;
                  state_reg <= STOP;
                end else begin
                  bit_reg   <= 3'd7;
                  byte_reg  <= 4'd0;
                  sda_out   <= rw_reg | data_reg[7];
                  state_reg <= DATA;
                end
              end

              DATA: begin
                if (rw_reg) begin
                  shift_reg <= rx_byte[6:0];
                end
                if (bit_reg == 3'd0) begin
                  if (rw_reg) begin
                    rdata[{byte_reg, 3'b000} +: 8] <= rx_byte;
                  end
                  // Reads: ACK every byte but the last, which is NACKed.
                  sda_out   <= rw_reg ? last_byte : 1'b1;
                  state_reg <= DATA_ACK;
                end else begin
                  bit_reg <= bit_dec;
                  sda_out <= rw_reg | tx_byte[bit_dec];
                end
              end

              DATA_ACK: begin
                if (!rw_reg && sda_in) begin
                  ack_error <= 1'b1;
                  sda_out   <= 1'b0;
                  state_reg <= STOP;
                end else if (last_byte) begin
                  sda_out   <= 1'b0;
                  state_reg <= STOP;
                end else begin
                  byte_reg  <= byte_inc;
                  bit_reg   <= 3'd7;
                  sda_out   <= rw_reg | tx_next_byte[7];
                  state_reg <= DATA;
                end
              end

              default: state_reg <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a behavioural I2C slave.
// The slave decodes the bus, pushes every byte seen on SDA into a queue and
// records the master's ACK bits during reads; the main sequence pushes the
// expected bytes before each transaction and compares afterwards.
module tb_i2c_master;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [6:0]   addr = 7'd0;
  logic         rw = 1'b0;
  logic [4:0]   packets = 5'd0;
  logic [127:0] data = '0;
  logic         ready;
  logic [127:0] rdata;
  logic         ack_error;
  logic         scl;
  logic         sda_out;
  logic         slave_drive = 1'b1;
  wire          sda_in = sda_out & slave_drive;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2c_master dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .rw        (rw),
    .packets   (packets),
    .data      (data),
    .ready     (ready),
    .rdata     (rdata),
    .ack_error (ack_error),
    .scl       (scl),
    .sda_out   (sda_out),
    .sda_in    (sda_in)
  );

  // ---------------- slave model ----------------
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         bit_idx = 0;
  int         byte_num = 0;
  logic       is_read = 1'b0;
  logic       done = 1'b0;
  logic       nack_addr = 1'b0;
  logic [7:0] shreg = 8'd0;
  logic [7:0] rd_bytes [16];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       mack_q[$];
  logic       exp_mack_q[$];
  int         stop_cnt = 0;

  always @(negedge clk) begin
    if (prev_scl && scl && prev_sda && !sda_in) begin
      bit_idx = 0; byte_num = 0; done = 1'b0; is_read = 1'b0; slave_drive = 1'b1;
    end else if (prev_scl && scl && !prev_sda && sda_in) begin
      stop_cnt++;
    end else if (!prev_scl && scl) begin
      if (bit_idx < 8) shreg = {shreg[6:0], sda_in};
      else if (bit_idx == 8 && is_read && byte_num >= 1) begin
        mack_q.push_back(sda_in);
        if (sda_in) done = 1'b1;
      end
      bit_idx++;
    end else if (prev_scl && !scl) begin
      if (bit_idx == 8) begin
        got_q.push_back(shreg);
        if (byte_num == 0) begin
          is_read = shreg[0];
          done = nack_addr;
          slave_drive = nack_addr;
        end else begin
          slave_drive = is_read ? 1'b1 : 1'b0;
        end
      end else if (bit_idx == 9) begin
        bit_idx = 0;
        byte_num++;
        if (is_read && !done && byte_num <= 16) slave_drive = rd_bytes[byte_num-1][7];
        else slave_drive = 1'b1;
      end else if (bit_idx >= 1 && bit_idx <= 7 && is_read && byte_num >= 1 && !done) begin
        slave_drive = rd_bytes[byte_num-1][7-bit_idx];
      end
    end
    prev_scl = scl;
    prev_sda = sda_in;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic [6:0] a, input logic r,
                         input logic [4:0] p, input logic [127:0] d,
                         input int exp_busy, input bit pulse);
    int cnt;
    int stops_before;
    stops_before = stop_cnt;
    @(negedge clk);
    addr = a; rw = r; packets = p; data = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 3000) begin
      if (pulse && cnt == 20) begin
        start = 1'b1; addr = 7'h7F; data = '1;
      end
      if (pulse && cnt == 24) start = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    check($sformatf("%s_busy_cycles", tag), cnt, exp_busy);
    @(negedge clk);
    check($sformatf("%s_stop_seen", tag), stop_cnt - stops_before, 1);
  endtask

  task automatic compare_bytes(input string tag);
    check($sformatf("%s_byte_count", tag), got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check($sformatf("%s_byte", tag), got_q.pop_front(), exp_q.pop_front());
    check($sformatf("%s_mack_count", tag), mack_q.size(), exp_mack_q.size());
    while (mack_q.size() > 0 && exp_mack_q.size() > 0)
      check($sformatf("%s_master_ack", tag), mack_q.pop_front(), exp_mack_q.pop_front());
    got_q.delete(); exp_q.delete(); mack_q.delete(); exp_mack_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] big;
    for (int i = 0; i < 16; i++) rd_bytes[i] = 8'h00;

    // Reset, with start held high to show reset wins.
    reset = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready, 1);
    check("reset_scl", scl, 1);
    check("reset_sda_out", sda_out, 1);
    check("reset_ack_error", ack_error, 0);
    check("reset_rdata", rdata, 0);
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);

    // Write 2 bytes, with a start pulse while busy.
    exp_q.push_back(8'h42); exp_q.push_back(8'hF0); exp_q.push_back(8'hA0);
    run_txn("wr1", 7'h21, 1'b0, 5'd2, 128'hA0F0, 116, 1'b1);
    compare_bytes("wr1");
    check("wr1_ack_error", ack_error, 0);
    check("wr1_rdata_kept", rdata, 0);

    // Immediate restart.
    exp_q.push_back(8'h42); exp_q.push_back(8'hAA); exp_q.push_back(8'hFF);
    run_txn("wr2", 7'h21, 1'b0, 5'd2, 128'hFFAA, 116, 1'b0);
    compare_bytes("wr2");
    check("wr2_ack_error", ack_error, 0);

    // Read 2 bytes.
    rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'hC3;
    exp_q.push_back(8'h43); exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    exp_mack_q.push_back(1'b0); exp_mack_q.push_back(1'b1);
    run_txn("rd", 7'h21, 1'b1, 5'd2, 128'h0, 116, 1'b0);
    compare_bytes("rd");
    check("rd_rdata", rdata, 128'hC35A);
    check("rd_ack_error", ack_error, 0);

    // NACK on the address byte.
    nack_addr = 1'b1;
    exp_q.push_back(8'h42);
    run_txn("nack", 7'h21, 1'b0, 5'd2, 128'h1234, 44, 1'b0);
    compare_bytes("nack");
    check("nack_ack_error", ack_error, 1);
    check("nack_rdata_kept", rdata, 128'hC35A);
    nack_addr = 1'b0;

    // Zero data bytes; ack_error cleared by the new start.
    exp_q.push_back(8'hA4);
    run_txn("pkt0", 7'h52, 1'b0, 5'd0, 128'h0, 44, 1'b0);
    compare_bytes("pkt0");
    check("pkt0_ack_error", ack_error, 0);

    // packets above 16 clamps to 16.
    big = '0;
    for (int i = 0; i < 16; i++) big[i*8 +: 8] = 8'h30 + 8'(i);
    exp_q.push_back(8'h0E);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h30 + 8'(i));
    run_txn("clamp", 7'h07, 1'b0, 5'd20, big, 620, 1'b0);
    compare_bytes("clamp");

    // Reset in the middle of the address byte.
    @(negedge clk);
    addr = 7'h21; rw = 1'b0; packets = 5'd2; data = 128'hA0F0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("mid_busy", ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_ready", ready, 1);
    check("mid_reset_scl", scl, 1);
    check("mid_reset_sda_out", sda_out, 1);
    check("mid_reset_ack_error", ack_error, 0);
    check("mid_reset_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: transaction request, sampled only while ready=1.
REQ-004 SHALL have port addr, input, 7 bits: 7-bit target address.
REQ-005 SHALL have port rw, input, 1 bit: 0 = write, 1 = read; forms the R/W bit after addr.
REQ-006 SHALL have port packets, input, 5 bits: number of data bytes, 0..16.
REQ-007 SHALL have port data, input, 128 bits: write payload; byte i is data[i*8+7:i*8].
REQ-008 SHALL have port ready, output, 1 bit: 1 = idle and able to accept start.
REQ-009 SHALL have port rdata, output, 128 bits: read payload; byte i is rdata[i*8+7:i*8].
REQ-010 SHALL have port ack_error, output, 1 bit: set when a slave NACK aborts the transaction.
REQ-011 SHALL have port scl, output, 1 bit: I2C clock, driven push-pull.
REQ-012 SHALL have port sda_out, output, 1 bit: open-drain control; 0 = pull SDA low, 1 = release.
REQ-013 SHALL have port sda_in, input, 1 bit: sampled SDA line level.

Function
REQ-014 SHALL split every I2C bit into 4 clk phases: P0/P1 with scl=0, P2/P3 with scl=1; sda_out changes only in P0 and SDA is sampled in P3.
REQ-015 SHALL, in IDLE with ready=1 and start=1 on a rising edge, latch addr, rw, packets and data, clear ack_error, and drive ready=0 from the next cycle; start while ready=0 is ignored.
REQ-016 SHALL treat a latched packets value greater than 16 as 16.
REQ-017 SHALL run the states IDLE -> START -> ADDR (8 bits: addr[6:0] MSB-first, then rw) -> ADDR_ACK -> {DATA -> DATA_ACK} x packets -> STOP -> IDLE.
REQ-018 SHALL generate START as 4 cycles: scl=1 throughout, sda_out released for 2 cycles, then 0 for 2 cycles.
REQ-019 SHALL, in a write, send byte 0 first, then byte 1, and so on; each byte is sent MSB-first; sda_out is released during each ACK bit and sda_in is sampled in P3.
REQ-020 SHALL, when sda_in=1 at an ACK sample (NACK), set ack_error=1 and go directly to STOP, skipping the remaining bytes.
REQ-021 SHALL, in a read, release sda_out during data bits and shift sda_in MSB-first into rdata byte i.
REQ-022 SHALL, in a read, drive ACK (0) after every byte except the last, which gets NACK (released).
REQ-023 SHALL, for packets=0, send only START, the address byte with its ACK, and STOP.
REQ-024 SHALL generate STOP as 4 cycles: sda_out=0 in P0/P1 with scl=0, then scl=1 with sda_out=0 for 1 cycle, then sda_out released for 1 cycle.
REQ-025 SHALL return ready=1 in the cycle after STOP completes; the total busy time is 4*(2 + 9*(1+packets)) cycles.
REQ-026 SHALL hold rdata and ack_error stable from transaction end until the next accepted start; write transactions leave rdata unchanged.

Reset
REQ-027 SHALL, while reset=1, force state=IDLE, ready=1, scl=1, sda_out=1, ack_error=0 and rdata=0, aborting any transaction in progress without generating STOP.
REQ-028 SHALL give reset priority over start when both are 1 on the same edge.

Verification
REQ-029 SHALL be verified with reset, then addr=0x21, rw=0, packets=2, data=0xA0F0, slave ACKing -> SDA bytes 0x42, 0xF0, 0xA0; ready low for 4*(2+27)=116 cycles.
REQ-030 SHALL be verified by re-starting immediately after ready=1 with data=0xFFAA -> bytes 0x42, 0xAA, 0xFF; ack_error=0.
REQ-031 SHALL be verified with a read: addr=0x21, rw=1, packets=2, slave returning 0x5A then 0xC3 -> address byte 0x43, rdata[15:0]=0xC35A, master ACK after byte 0 and NACK after byte 1.
REQ-032 SHALL be verified with a NACK on the address byte -> ack_error=1, no data bytes sent, STOP issued, ready=1 after 4*(2+9) cycles.
REQ-033 SHALL be verified by asserting reset mid-byte -> next cycle ready=1, scl=1, sda_out=1, ack_error=0.
REQ-034 SHALL be verified by pulsing start while busy -> no effect on the transfer in progress.
